// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory wait states and a sticky illegal-opcode trap.
module multicycle_ctrl #(
    parameter int         INSTR_W       = 32,
    parameter int         ALUOP_W       = 4,
    parameter bit         MEM_HANDSHAKE = 1'b1,
    parameter logic [3:0] ALU_ADD       = 4'b0010,
    parameter logic [3:0] ALU_SUB       = 4'b0011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               mem_ready,
    input  logic               zero,
    output logic [3:0]         state,
    output logic [3:0]         next_state,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_R_EX     = 4'd2,
        S_R_WB     = 4'd3,
        S_I_EX     = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BR       = 4'd10,
        S_JMP      = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_BNE = 6'b100001;
    localparam logic [5:0] OP_SWI = 6'b111100;

    state_t     st_q;
    state_t     st_d;
    state_t     entry;
    logic [5:0] opcode;
    logic [5:0] op_q;
    logic       ready;
    logic [3:0] alu_op;
    logic       unused_instr_bits;

    assign opcode            = instr_in[INSTR_W-1 -: 6];
    assign unused_instr_bits = ^instr_in[INSTR_W-7:0];
    assign ready             = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        entry = S_TRAP;
        casez (opcode)
            6'b01????: entry = S_R_EX;
            6'b110???: entry = S_I_EX;
            6'b111001: entry = S_I_EX;
            6'b111010: entry = S_I_EX;
            6'b111011: entry = S_MEM_ADDR;
            6'b111100: entry = S_MEM_ADDR;
            6'b100000: entry = S_BR;
            6'b100001: entry = S_BR;
            6'b000001: entry = S_JMP;
            6'b000000: entry = S_FETCH;
            default:   entry = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q <= S_FETCH;
            op_q <= '0;
        end else begin
            st_q <= st_d;
            if (st_q == S_DECODE) op_q <= opcode;
        end
    end

    always_comb begin
        st_d        = st_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        alu_op      = 4'b0000;
        illegal     = 1'b0;
        case (st_q)
            // reset parks the FSM here, so this is the only state to silence
            S_FETCH: begin
                if (!reset) begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    alu_op  = ALU_ADD;
                    IRWrite = ready;
                    PCWrite = ready;
                    if (ready) st_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                alu_op  = ALU_ADD;
                st_d    = entry;
            end
            S_R_EX: begin
                ALUSrcA = 1'b1;
                alu_op  = op_q[3:0];
                st_d    = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                st_d     = S_FETCH;
            end
            S_I_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = op_q[3:0];
                st_d    = S_I_WB;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                st_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcB = 2'b10;
                alu_op  = op_q[3:0];
                st_d    = (op_q == OP_SWI) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (ready) st_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                st_d     = S_FETCH;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (ready) st_d = S_FETCH;
            end
            S_BR: begin
                ALUSrcA     = 1'b1;
                alu_op      = ALU_SUB;
                PCSource    = 2'b01;
                PCWriteCond = (op_q == OP_BEQ);
                PCWrite     = (op_q == OP_BNE) && !zero;
                st_d        = S_FETCH;
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                st_d     = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                st_d    = S_TRAP;
            end
            default: st_d = S_TRAP;
        endcase
    end

    assign state      = st_q;
    assign next_state = st_d;
    assign ALUOp      = ALUOP_W'(alu_op);

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle CPU control FSM, the successor to the fixed-width controller. It decodes the opcode field of the instruction register output and sequences fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write strobes. Unlike the previous generation, it adds:
- a memory ready handshake with wait states;
- an internal opcode latch, so it is insensitive to instr_in changing after decode;
- a store instruction (SWI) and BNE;
- a sticky illegal-opcode trap.

## Interface
- INSTR_W, 32, instruction width (≥32); opcode = instr_in[INSTR_W-1:INSTR_W-6]
- ALUOP_W, 4, ALUOp width (≥4); upper bits always 0
- MEM_HANDSHAKE, 1, 1: honour mem_ready; 0: mem_ready treated as constant 1
- ALU_ADD, 4'b0010, ALU code used for PC increment / branch target
- ALU_SUB, 4'b0011, ALU code used for branch compare
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  asynchronous, active-high
- instr_in  in  INSTR_W  instruction register output
- mem_ready  in  1  memory access completes this cycle
- zero  in  1  ALU zero flag (BNE inversion only; BEQ uses the datapath's PCWriteCond AND zero)
- state, next_state  out  4  current / combinational next state
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  out  1  datapath controls
- PCSource, ALUSrcB  out  2  mux selects
- ALUOp  out  ALUOP_W  ALU function
- illegal  out  1  trap flag

## Operation
- States: FETCH=0, DECODE=1, R_EX=2, R_WB=3, I_EX=4, I_WB=5, MEM_ADDR=6, MEM_RD=7, MEM_WB=8, MEM_WR=9, BR=10, JMP=11, TRAP=15. Codes 12–14 are unreachable and go to TRAP.
- Opcode classes:
  - 01xxxx: R-type (ADD=010010)
  - 110xxx: I-ALU (ADDI=110010)
  - LI=111001, LUI=111010: I_EX path
  - LWI=111011
  - SWI=111100
  - BEQ=100000, BNE=100001
  - J=000001
  - NOOP=000000
  - anything else: illegal
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ALU_ADD, PCSource=00.
  - IRWrite = PCWrite = ready.
  - Stays in FETCH until ready, then goes to DECODE.
- DECODE:
  - Latches the opcode into op_q.
  - ALUSrcA=0, ALUSrcB=11, ALUOp=ALU_ADD (branch target).
  - Branches to the class entry state. NOOP goes to FETCH; illegal goes to TRAP.
  - All later states use op_q only.
- R_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=op_q[3:0]. Then R_WB: RegWrite=1, RegDst=1, MemtoReg=0.
- I_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=op_q[3:0] (LI/LUI codes 1001/1010 select pass/shift in the ALU). Then I_WB: RegWrite=1, RegDst=0.
- MEM_ADDR: ALUSrcB=10, ALUOp=op_q[3:0]. Goes to MEM_RD (LWI) or MEM_WR (SWI).
- MEM_RD: IorD=1, MemRead=1. Holds until ready, then goes to MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0.
- MEM_WR: IorD=1, MemWrite=1. Holds until ready, then goes to FETCH.
- BR:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=ALU_SUB, PCSource=01.
  - BEQ: PCWriteCond=1.
  - BNE: PCWrite = ~zero, PCWriteCond=0.
  - Then FETCH.
- JMP: PCWrite=1, PCSource=10. Then FETCH.
- TRAP:
  - illegal=1, all strobes 0.
  - Held until reset; the only exit is reset.
- Any control output not listed for a state is 0.

## Timing
- Reset asserted: state = next_state = 0 asynchronously. All controls and illegal are 0 while reset is high; there are no strobes in the reset cycle.
- First FETCH strobes appear in the first cycle after reset deasserts.
- Reset mid-instruction aborts it. The pending RegWrite/MemWrite/PCWrite does not occur.
- Outputs are Moore from state, except:
  - IRWrite/PCWrite in FETCH, gated combinationally by ready;
  - PCWrite in BR for BNE, gated by zero.
- Cycle counts with zero wait states:
  - NOOP 2
  - J and branches 3
  - R, I-ALU, LI, LUI, SWI 4
  - LWI 5
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle and produces no strobe.
- With MEM_HANDSHAKE=0, latencies are fixed regardless of mem_ready.
- instr_in changes after DECODE do not alter the sequence.

## Test plan
- Reset mid-R_WB → state=0, RegWrite=0 immediately. The next cycle is FETCH with MemRead=1, IRWrite=1.
- ADD 0x48000000, mem_ready=1 → states 0,1,2,3,0. R_WB has RegWrite=1, RegDst=1. R_EX has ALUOp=0010.
- LWI 0xEC000000, mem_ready low for 2 cycles in MEM_RD → states 0,1,6,7,7,7,8,0. MemtoReg=1 only in state 8.
- SWI 0xF0000000 with MEM_HANDSHAKE=0 and mem_ready=0 → states 0,1,6,9,0. MemWrite=1 for exactly one cycle.
- BNE 0x84000000 → PCWrite=1 in BR when zero=0, PCWrite=0 when zero=1. BEQ 0x83E00010 → PCWriteCond=1, PCSource=01.
- Opcode 0x3F (0xFC000000) → TRAP, illegal=1, no strobes for 20 cycles. Asserting reset clears illegal and returns to FETCH.
- LI 0xE400FFFE with instr_in changed to J during I_EX → sequence still reaches I_WB with RegWrite=1.
